// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM controller KMAC packer.
//
// Contents:
//   PackerStateWidth - width of the sparse packer state encoding
//   packer_state_e   - sparse 6-bit state encoding, pairwise Hamming distance >= 3
//   low_half_strb    - helper building the strobe for a half-filled beat
package rom_ctrl_pkg;

    localparam int unsigned PackerStateWidth = 6;

    // Every pair of codes differs in at least 3 bits, so a single or double
    // bit upset can never turn one legal state into another.
    typedef enum logic [PackerStateWidth-1:0] {
        StEmpty   = 6'b001011,
        StHalf    = 6'b110001,
        StFull    = 6'b010110,
        StDone    = 6'b101100,
        StInvalid = 6'b111111
    } packer_state_e;

    // Strobe for a beat whose lower half only is populated.
    function automatic logic [15:0] low_half_strb(input int unsigned word_width);
        logic [15:0] strb;
        strb = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < word_width / 8) begin
                strb[i] = 1'b1;
            end
        end
        return strb;
    endfunction

endpackage

// File: rtl/prim_sparse_fsm_flop.sv
// State register for sparse-encoded FSMs.
//
// Holds the raw encoding, so a corrupted value stays visible to the FSM's
// default decode instead of being collapsed onto a legal state.
//
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset, loads ResetValue
//   state_i - next-state encoding
//   state_o - current-state encoding
module prim_sparse_fsm_flop #(
    parameter int unsigned       Width      = 6,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] state_i,
    output logic [Width-1:0] state_o
);

    logic [Width-1:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ResetValue;
        end else begin
            state_q <= state_i;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rom_ctrl_packer_chk.sv
// Handshake protocol checker for the ROM word interface of the KMAC packer.
//
// Once the FSM side presents a word that is not accepted (word_vld_i high,
// word_rdy_i low), it must keep presenting the same word until accepted.
// Dropping valid, or changing word_i / word_last_i, flags err_o for one cycle.
//
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   word_vld_i    - word valid from FSM side
//   word_rdy_i    - packer ready (observed)
//   word_i        - word data
//   word_last_i   - word last flag
//   err_o         - protocol violation seen this cycle
module rom_ctrl_packer_chk #(
    parameter int unsigned WordWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 word_vld_i,
    input  logic                 word_rdy_i,
    input  logic [WordWidth-1:0] word_i,
    input  logic                 word_last_i,
    output logic                 err_o
);

    logic                 stalled_q;
    logic [WordWidth-1:0] word_q;
    logic                 last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stalled_q <= 1'b0;
            word_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            stalled_q <= word_vld_i && !word_rdy_i;
            word_q    <= word_i;
            last_q    <= word_last_i;
        end
    end

    always_comb begin
        err_o = 1'b0;
        if (stalled_q) begin
            err_o = !word_vld_i || (word_i != word_q) || (word_last_i != last_q);
        end
    end

endmodule

// File: rtl/rom_ctrl_kmac_packer.sv
// Packs pairs of ROM words into double-width beats for the KMAC message port.
//
// Optional build macro: ROM_CTRL_PACKER_PROT_CHECK_EN enables the word-side
// handshake protocol checker; any violation drives the FSM to Invalid.
//
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   word_vld_i    - ROM word valid
//   word_i        - ROM word data
//   word_last_i   - word is last of message
//   word_rdy_o    - word accepted this cycle when high with word_vld_i
//   msg_valid_o   - beat valid to KMAC
//   msg_data_o    - packed beat {upper word, lower word}
//   msg_strb_o    - byte strobe for the beat
//   msg_last_o    - beat ends message
//   msg_ready_i   - KMAC accepts beat
//   alert_o       - fatal error, sticky until reset
module rom_ctrl_kmac_packer
    import rom_ctrl_pkg::*;
#(
    parameter int unsigned WordWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     word_vld_i,
    input  logic [WordWidth-1:0]     word_i,
    input  logic                     word_last_i,
    output logic                     word_rdy_o,
    output logic                     msg_valid_o,
    output logic [2*WordWidth-1:0]   msg_data_o,
    output logic [2*WordWidth/8-1:0] msg_strb_o,
    output logic                     msg_last_o,
    input  logic                     msg_ready_i,
    output logic                     alert_o
);

    localparam int unsigned StrbWidth = 2 * WordWidth / 8;

    localparam logic [15:0] LowStrbFull = low_half_strb(WordWidth);
    localparam logic [StrbWidth-1:0] LowStrb = LowStrbFull[StrbWidth-1:0];

    packer_state_e                state_q, state_d;
    logic [PackerStateWidth-1:0]  state_raw;
    logic [2*WordWidth-1:0]       data_q, data_d;
    logic [StrbWidth-1:0]         strb_q, strb_d;
    logic                         last_q, last_d;
    logic                         accept;
    logic                         prot_err;

`ifdef ROM_CTRL_PACKER_PROT_CHECK_EN
    rom_ctrl_packer_chk #(
        .WordWidth (WordWidth)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .word_vld_i  (word_vld_i),
        .word_rdy_i  (word_rdy_o),
        .word_i      (word_i),
        .word_last_i (word_last_i),
        .err_o       (prot_err)
    );
`else
    assign prot_err = 1'b0;
`endif

    prim_sparse_fsm_flop #(
        .Width      (PackerStateWidth),
        .ResetValue (StEmpty)
    ) u_state_regs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .state_i (state_d),
        .state_o (state_raw)
    );

    assign state_q = packer_state_e'(state_raw);

    // Ready depends on registered state only, never on msg_ready_i.
    assign word_rdy_o = (state_q == StEmpty) || (state_q == StHalf);
    assign accept     = word_vld_i && word_rdy_o;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;

        case (state_q)
            StEmpty: begin
                if (accept) begin
                    // Upper half is cleared so a lone last word gives a clean beat.
                    data_d = {{WordWidth{1'b0}}, word_i};
                    if (word_last_i) begin
                        strb_d  = LowStrb;
                        last_d  = 1'b1;
                        state_d = StFull;
                    end else begin
                        strb_d  = '0;
                        last_d  = 1'b0;
                        state_d = StHalf;
                    end
                end
            end
            StHalf: begin
                if (accept) begin
                    data_d[2*WordWidth-1:WordWidth] = word_i;
                    strb_d  = '1;
                    last_d  = word_last_i;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (msg_ready_i) begin
                    state_d = last_q ? StDone : StEmpty;
                end
            end
            StDone: begin
                if (word_vld_i) begin
                    state_d = StInvalid;
                end
            end
            StInvalid: begin
                state_d = StInvalid;
            end
            default: begin
                state_d = StInvalid;
            end
        endcase

        if (prot_err) begin
            state_d = StInvalid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            strb_q <= '0;
            last_q <= 1'b0;
        end else begin
            data_q <= data_d;
            strb_q <= strb_d;
            last_q <= last_d;
        end
    end

    assign msg_valid_o = (state_q == StFull);
    assign msg_data_o  = msg_valid_o ? data_q : '0;
    assign msg_strb_o  = msg_valid_o ? strb_q : '0;
    assign msg_last_o  = msg_valid_o && last_q;

    // Any encoding outside the four working states is fatal; Invalid is
    // terminal, so this stays high until reset.
    assign alert_o = !((state_q == StEmpty) || (state_q == StHalf) ||
                       (state_q == StFull)  || (state_q == StDone));

endmodule

// File: tb/tb_rom_ctrl_kmac_packer.sv
// Directed self-checking bench for rom_ctrl_kmac_packer (WordWidth = 32).
// Inputs change on the falling edge; outputs are checked on the falling edge,
// i.e. half a cycle after the rising edge that updated them.
module tb_rom_ctrl_kmac_packer;

    logic        clk_i;
    logic        rst_ni;
    logic        word_vld_i;
    logic [31:0] word_i;
    logic        word_last_i;
    logic        word_rdy_o;
    logic        msg_valid_o;
    logic [63:0] msg_data_o;
    logic [7:0]  msg_strb_o;
    logic        msg_last_o;
    logic        msg_ready_i;
    logic        alert_o;

    int checks = 0;
    int errors = 0;

    rom_ctrl_kmac_packer #(
        .WordWidth (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .word_vld_i  (word_vld_i),
        .word_i      (word_i),
        .word_last_i (word_last_i),
        .word_rdy_o  (word_rdy_o),
        .msg_valid_o (msg_valid_o),
        .msg_data_o  (msg_data_o),
        .msg_strb_o  (msg_strb_o),
        .msg_last_o  (msg_last_o),
        .msg_ready_i (msg_ready_i),
        .alert_o     (alert_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic drive(input logic vld, input logic [31:0] w, input logic last);
        word_vld_i  = vld;
        word_i      = w;
        word_last_i = last;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy"},   {63'h0, word_rdy_o},  64'h1);
        check({tag, "_valid"}, {63'h0, msg_valid_o}, 64'h0);
        check({tag, "_data"},  msg_data_o,           64'h0);
        check({tag, "_strb"},  {56'h0, msg_strb_o},  64'h0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        msg_ready_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);

        // Reset state
        next_cycle();
        check_idle("reset");
        check("reset_last",  {63'h0, msg_last_o}, 64'h0);
        check("reset_alert", {63'h0, alert_o},    64'h0);
        rst_ni = 1'b1;

        // Two words, second last, KMAC always ready
        msg_ready_i = 1'b1;
        drive(1'b1, 32'h11111111, 1'b0);
        next_cycle();
        check_idle("t1_half");
        drive(1'b1, 32'h22222222, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        check("t1_valid", {63'h0, msg_valid_o}, 64'h1);
        check("t1_data",  msg_data_o,           64'h22222222_11111111);
        check("t1_strb",  {56'h0, msg_strb_o},  64'hFF);
        check("t1_last",  {63'h0, msg_last_o},  64'h1);
        check("t1_rdy",   {63'h0, word_rdy_o},  64'h0);
        next_cycle();
        check("t1_done_valid", {63'h0, msg_valid_o}, 64'h0);
        check("t1_done_rdy",   {63'h0, word_rdy_o},  64'h0);
        check("t1_done_alert", {63'h0, alert_o},     64'h0);

        // Word offered in Done raises a sticky alert
        drive(1'b1, 32'h33333333, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        check("done_alert", {63'h0, alert_o}, 64'h1);
        repeat (3) next_cycle();
        check("done_alert_sticky", {63'h0, alert_o},     64'h1);
        check("done_alert_valid",  {63'h0, msg_valid_o}, 64'h0);
        do_reset();
        check("alert_cleared", {63'h0, alert_o}, 64'h0);

        // Three words: full beat then half beat
        drive(1'b1, 32'hA0A0A0A0, 1'b0);
        next_cycle();
        drive(1'b1, 32'hB0B0B0B0, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        check("t3_b0_data", msg_data_o,          64'hB0B0B0B0_A0A0A0A0);
        check("t3_b0_strb", {56'h0, msg_strb_o}, 64'hFF);
        check("t3_b0_last", {63'h0, msg_last_o}, 64'h0);
        next_cycle();
        check_idle("t3_empty");
        drive(1'b1, 32'hC0C0C0C0, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        check("t3_b1_valid", {63'h0, msg_valid_o}, 64'h1);
        check("t3_b1_data",  msg_data_o,           64'h00000000_C0C0C0C0);
        check("t3_b1_strb",  {56'h0, msg_strb_o},  64'h0F);
        check("t3_b1_last",  {63'h0, msg_last_o},  64'h1);
        next_cycle();
        check("t3_done_valid", {63'h0, msg_valid_o}, 64'h0);
        do_reset();

        // Back-pressure: beat held stable for 5 cycles
        msg_ready_i = 1'b0;
        drive(1'b1, 32'hD1D1D1D1, 1'b0);
        next_cycle();
        drive(1'b1, 32'hD2D2D2D2, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {63'h0, msg_valid_o}, 64'h1);
            check("stall_data",  msg_data_o,           64'hD2D2D2D2_D1D1D1D1);
            check("stall_strb",  {56'h0, msg_strb_o},  64'hFF);
            check("stall_rdy",   {63'h0, word_rdy_o},  64'h0);
            if (i == 4) msg_ready_i = 1'b1;
            next_cycle();
        end
        check_idle("stall_released");
        check("stall_alert", {63'h0, alert_o}, 64'h0);
        do_reset();

        // Word changes while stalled in Full
        msg_ready_i = 1'b0;
        drive(1'b1, 32'h12345678, 1'b0);
        next_cycle();
        drive(1'b1, 32'h000000AA, 1'b0);
        next_cycle();
        // Now Full; keep presenting a stalled word, then change it
        next_cycle();
        drive(1'b1, 32'h000000BB, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
`ifdef ROM_CTRL_PACKER_PROT_CHECK_EN
        check("prot_alert", {63'h0, alert_o},     64'h1);
        check("prot_valid", {63'h0, msg_valid_o}, 64'h0);
`else
        check("prot_alert", {63'h0, alert_o},     64'h0);
        check("prot_data",  msg_data_o,           64'h000000AA_12345678);
`endif
        do_reset();

        // Reset pulsed while in Half discards the buffered word
        msg_ready_i = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check_idle("mid_reset");
        #1 rst_ni = 1'b1;
        next_cycle();
        check_idle("after_reset");
        drive(1'b1, 32'h01020304, 1'b0);
        next_cycle();
        drive(1'b1, 32'h05060708, 1'b1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0);
        check("clean_data", msg_data_o,          64'h05060708_01020304);
        check("clean_strb", {56'h0, msg_strb_o}, 64'hFF);
        check("clean_last", {63'h0, msg_last_o}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
